branch_flag_unit: RTL

Holds the architectural NZCV flags and resolves conditional branches (B.cond, CBZ, CBNZ) for the pipelined LEGv8 core. It sits directly downstream of the EX-stage 64-bit zero detector and ALU flag logic, latching their outputs on flag-setting instructions. It also consumes the zero-detect of the CBZ/CBNZ operand. It delivers a registered taken/not-taken decision to the fetch/flush control.

---
 rtl/legv8_flags_pkg.sv | 42 ++++
 rtl/bcond_eval.sv | 42 ++++
 rtl/branch_flag_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/legv8_flags_pkg.sv
// Shared types and constants for the LEGv8 NZCV flag register and the
// conditional-branch resolution logic.
package legv8_flags_pkg;

  // LEGv8 condition codes as encoded in B.cond.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Conditional branch flavours presented by the ID stage.
  typedef enum logic [1:0] {
    BR_BCOND = 2'b00,
    BR_CBZ   = 2'b01,
    BR_CBNZ  = 2'b10,
    BR_RSVD  = 2'b11
  } br_kind_e;

  // Bit positions inside the packed {N,Z,C,V} flag vector.
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Architectural flag value after reset.
  localparam logic [3:0] FLAGS_RESET = 4'b0000;

endpackage

// File: rtl/bcond_eval.sv
// Combinational evaluation of a LEGv8 condition code against an NZCV vector.
// Kept standalone so conditional-select logic can share it later.
module bcond_eval
  import legv8_flags_pkg::*;
(
  input  cond_e      cond,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic n, z, c, v;

  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];

  // Map each condition code to its flag predicate; AL and NV always take.
  always_comb begin
    taken = 1'b1;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_HS: taken = c;
      COND_LO: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c & !z;
      COND_LS: taken = !(c & !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z & (n == v);
      COND_LE: taken = !(!z & (n == v));
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_flag_unit.sv
// Architectural NZCV register plus conditional-branch resolver (B.cond, CBZ,
// CBNZ). The decision is registered: a branch sitting in ID during cycle t
// shows up as br_done/br_taken during cycle t+1.
//
// Issue protocol: id_br_valid qualifies id_br_kind/id_cond/id_rt_zero in the
// same cycle. A branch is consumed (resolved) in a cycle where id_br_valid=1,
// flush=0, stall=0 and flag_stall=0; otherwise the upstream logic must keep
// presenting it (or flush it). br_done is a single-cycle pulse per resolved
// branch and br_taken is only meaningful while br_done=1.
module branch_flag_unit
  import legv8_flags_pkg::*;
#(
  parameter int FORWARD_EN = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       stall,
  input  logic       flush,
  input  logic       ex_set_flags,
  input  logic       ex_zero,
  input  logic       ex_neg,
  input  logic       ex_carry,
  input  logic       ex_ovf,
  input  logic       id_br_valid,
  input  logic [1:0] id_br_kind,
  input  logic [3:0] id_cond,
  input  logic       id_rt_zero,
  output logic [3:0] flags,
  output logic       br_done,
  output logic       br_taken,
  output logic       flag_stall
);

  localparam bit FWD = (FORWARD_EN != 0);

  logic [3:0] ex_nzcv;
  logic [3:0] eff_flags;
  logic       is_bcond;
  logic       cond_taken;
  logic       fire;
  logic       taken_next;
  br_kind_e   kind;

  assign ex_nzcv  = {ex_neg, ex_zero, ex_carry, ex_ovf};
  assign kind     = br_kind_e'(id_br_kind);
  assign is_bcond = (kind == BR_BCOND);

  // Bypass: a flag-setting instruction in EX feeds a B.cond in ID directly.
  assign eff_flags = (FWD && ex_set_flags) ? ex_nzcv : flags;

  // Without the bypass, a B.cond must wait for the EX flag write to land.
  assign flag_stall = !FWD && id_br_valid && is_bcond && ex_set_flags;

  assign fire = id_br_valid && !flush && !stall && !flag_stall;

  bcond_eval u_bcond_eval (
    .cond  (cond_e'(id_cond)),
    .nzcv  (eff_flags),
    .taken (cond_taken)
  );

  // Select the decision for the branch flavour; reserved kind never takes.
  always_comb begin
    taken_next = 1'b0;
    case (kind)
      BR_BCOND: taken_next = cond_taken;
      BR_CBZ:   taken_next = id_rt_zero;
      BR_CBNZ:  taken_next = !id_rt_zero;
      BR_RSVD:  taken_next = 1'b0;
      default:  taken_next = 1'b0;
    endcase
  end

  // NZCV register: written by flag-setting EX instructions unless frozen.
  // flush only targets the younger branch in ID, so it does not block this.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= FLAGS_RESET;
    end else if (ex_set_flags && !stall) begin
      flags <= ex_nzcv;
    end
  end

  // Registered decision: one pulse per resolved branch, cleared otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else begin
      br_done  <= fire;
      br_taken <= fire && taken_next;
    end
  end

endmodule
